// File: rtl/xadac_pkg.sv
// Shared types for the XADAC dispatcher: instruction, operand and
// request/response payload formats exchanged with the execution units.
package xadac_pkg;

  typedef logic [3:0]  IdT;
  typedef logic [31:0] InstrT;
  typedef logic [31:0] XlenT;
  typedef logic [63:0] VectorT;

  typedef struct packed {
    IdT     id;
    InstrT  instr;
    XlenT   rs1;
    XlenT   rs2;
    VectorT vs1;
    VectorT vs2;
    VectorT vs3;
  } ReqPayloadT;

  typedef struct packed {
    logic rs1_read;
    logic rs2_read;
    logic vs1_read;
    logic vs2_read;
    logic vs3_read;
    logic rd_clobber;
    logic vd_clobber;
  } ReqFlagsT;

  typedef struct packed {
    IdT     id;
    XlenT   rd;
    VectorT vd;
    logic   rd_write;
    logic   vd_write;
  } RespPayloadT;

endpackage

// File: rtl/xadac_dispatch_if.sv
// Upstream request/response handshakes plus the per-unit request/response
// buses of the dispatcher; slave is the dispatcher's view, master its environment.
interface xadac_dispatch_if #(
  parameter int unsigned NoUnits = 4
) ();
  import xadac_pkg::*;

  logic                             req_valid;
  logic                             req_ready;
  ReqPayloadT                       req_payload;
  ReqFlagsT                         req_flags;
  logic                             req_accept;

  logic        [NoUnits-1:0]        unit_req_valid;
  logic        [NoUnits-1:0]        unit_req_ready;
  ReqPayloadT  [NoUnits-1:0]        unit_req_payload;
  ReqFlagsT    [NoUnits-1:0]        unit_req_flags;
  logic        [NoUnits-1:0]        unit_req_accept;

  logic        [NoUnits-1:0]        unit_resp_valid;
  logic        [NoUnits-1:0]        unit_resp_ready;
  RespPayloadT [NoUnits-1:0]        unit_resp_payload;

  logic                             resp_valid;
  logic                             resp_ready;
  RespPayloadT                      resp_payload;

  modport slave (
    input  req_valid, req_payload, unit_req_ready, unit_req_flags, unit_req_accept,
    input  unit_resp_valid, unit_resp_payload, resp_ready,
    output req_ready, req_flags, req_accept, unit_req_valid, unit_req_payload,
    output unit_resp_ready, resp_valid, resp_payload
  );

  modport master (
    output req_valid, req_payload, unit_req_ready, unit_req_flags, unit_req_accept,
    output unit_resp_valid, unit_resp_payload, resp_ready,
    input  req_ready, req_flags, req_accept, unit_req_valid, unit_req_payload,
    input  unit_resp_ready, resp_valid, resp_payload
  );

endinterface

// File: rtl/xadac_rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr moves past the winner
// whenever the grant is consumed (advance).
module xadac_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_idx
);

  logic [IdxW-1:0] ptr_q;

  always_comb begin
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr_q) + k) % int'(N);
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/xadac_dispatch.sv
// Decodes upstream instructions onto one of NoUnits execution units with a
// per-unit outstanding limit, and merges unit responses through a registered output.
module xadac_dispatch
  import xadac_pkg::*;
#(
  parameter int unsigned NoUnits                = 4,
  parameter int unsigned MaxOutstanding         = 4,
  parameter InstrT       MaskTable  [NoUnits]   = '{default: '0},
  parameter InstrT       MatchTable [NoUnits]   = '{default: '1}
) (
  input  logic            clk,
  input  logic            rstn,
  xadac_dispatch_if.slave bus,
  output logic            err
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned IdxW = (NoUnits > 1) ? $clog2(NoUnits) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(MaxOutstanding);

  cnt_t               count_q [NoUnits];
  logic               err_q;
  logic               hit;
  logic [IdxW-1:0]    sel;
  logic [NoUnits-1:0] req_hs;
  logic [NoUnits-1:0] rsp_hs;
  logic [NoUnits-1:0] grant;
  logic [IdxW-1:0]    grant_idx;
  logic               out_free;
  logic               resp_valid_q;
  RespPayloadT        resp_payload_q;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = int'(NoUnits) - 1; i >= 0; i--) begin
      if ((bus.req_payload.instr & MaskTable[i]) == MatchTable[i]) begin
        hit = 1'b1;
        sel = IdxW'(i);
      end
    end
  end

  // A full unit stalls without looking at its ready, keeping ready off the path.
  always_comb begin
    bus.unit_req_valid = '0;
    bus.req_ready      = 1'b0;
    bus.req_accept     = 1'b0;
    bus.req_flags      = '0;
    for (int i = 0; i < int'(NoUnits); i++) begin
      bus.unit_req_payload[i] = bus.req_payload;
    end
    if (bus.req_valid) begin
      if (!hit) begin
        bus.req_ready = 1'b1;
      end else if (count_q[sel] < CntMax) begin
        bus.unit_req_valid[sel] = 1'b1;
        bus.req_ready           = bus.unit_req_ready[sel];
        bus.req_accept          = bus.unit_req_accept[sel];
        bus.req_flags           = bus.unit_req_flags[sel];
      end
    end
  end

  assign req_hs              = bus.unit_req_valid & bus.unit_req_ready & bus.unit_req_accept;
  assign out_free            = !resp_valid_q || bus.resp_ready;
  assign bus.unit_resp_ready = out_free ? grant : '0;
  assign rsp_hs              = bus.unit_resp_valid & bus.unit_resp_ready;

  xadac_rr_arbiter #(
    .N (NoUnits)
  ) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .req       (bus.unit_resp_valid),
    .advance   (|rsp_hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NoUnits); i++) count_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NoUnits); i++) begin
        if (rsp_hs[i] && count_q[i] == '0) err_q <= 1'b1;
        if (req_hs[i] && !rsp_hs[i]) begin
          count_q[i] <= count_q[i] + cnt_t'(1);
        end else if (rsp_hs[i] && !req_hs[i] && count_q[i] != '0) begin
          count_q[i] <= count_q[i] - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_valid_q   <= 1'b0;
      resp_payload_q <= '0;
    end else if (|rsp_hs) begin
      resp_valid_q   <= 1'b1;
      resp_payload_q <= bus.unit_resp_payload[grant_idx];
    end else if (bus.resp_ready) begin
      resp_valid_q   <= 1'b0;
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_payload = resp_payload_q;
  assign err              = err_q;

endmodule
